// File: rtl/regfile_mp_if.sv
// Register file bus: clear request/status, shared-enable read ports,
// two byte-masked write ports. master drives requests, slave is the file.
interface regfile_mp_if #(
  parameter int N  = 64,
  parameter int R  = 32,
  parameter int RP = 2
);
  localparam int ASIZE = ($clog2(R) > 1) ? $clog2(R) : 1;
  localparam int NB    = N / 8;

  logic               clr;
  logic               busy;
  logic               rd_en;
  logic [RP*ASIZE-1:0] rd_addr;
  logic [RP*N-1:0]    rd_data;
  logic [1:0]         wr_en;
  logic [ASIZE-1:0]   wr_addr0;
  logic [ASIZE-1:0]   wr_addr1;
  logic [N-1:0]       wr_data0;
  logic [N-1:0]       wr_data1;
  logic [NB-1:0]      wr_be0;
  logic [NB-1:0]      wr_be1;

  modport master (
    output clr, rd_en, rd_addr,
    output wr_en, wr_addr0, wr_addr1,
    output wr_data0, wr_data1, wr_be0, wr_be1,
    input  busy, rd_data
  );

  modport slave (
    input  clr, rd_en, rd_addr,
    input  wr_en, wr_addr0, wr_addr1,
    input  wr_data0, wr_data1, wr_be0, wr_be1,
    output busy, rd_data
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: RP registered read ports with write-first
// bypass, two byte-masked write ports, one-register-per-cycle clear sweep.
// Ports: clk, rst (sync, active-high), bus (regfile_mp_if.slave).
module regfile_mp #(
  parameter int N        = 64,
  parameter int R        = 32,
  parameter int RP       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);
  localparam int ASIZE = ($clog2(R) > 1) ? $clog2(R) : 1;
  localparam int NB    = N / 8;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           state;
  logic [ASIZE-1:0] cnt;
  logic             busy_q;
  logic [RP*N-1:0]  rd_q;
  logic [N-1:0]     mem [R];
  logic             ok0;
  logic             ok1;

  function automatic logic in_range(
    input logic [ASIZE-1:0] a
  );
    return (ASIZE+1)'(a) < (ASIZE+1)'(R);
  endfunction

  // Address 0 is neither writable nor readable when hardwired to zero.
  function automatic logic live(
    input logic [ASIZE-1:0] a
  );
    return in_range(a) && !(ZERO_REG != 0 && a == '0);
  endfunction

  function automatic logic [N-1:0] merge(
    input logic [N-1:0]  v,
    input logic [N-1:0]  d,
    input logic [NB-1:0] be
  );
    logic [N-1:0] r;
    r = v;
    for (int b = 0; b < NB; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Post-write value of a live register: port 1 is applied last so
  // it wins on bytes both ports enable. Used for writes and bypass.
  function automatic logic [N-1:0] post(
    input logic [ASIZE-1:0] a
  );
    logic [N-1:0] v;
    v = mem[a];
    if (ok0 && bus.wr_addr0 == a)
      v = merge(v, bus.wr_data0, bus.wr_be0);
    if (ok1 && bus.wr_addr1 == a)
      v = merge(v, bus.wr_data1, bus.wr_be1);
    return v;
  endfunction

  assign ok0 = (state == S_IDLE) && bus.wr_en[0]
             && live(bus.wr_addr0);
  assign ok1 = (state == S_IDLE) && bus.wr_en[1]
             && live(bus.wr_addr1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_CLEAR;
      cnt    <= '0;
      busy_q <= 1'b1;
      rd_q   <= '0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          mem[cnt] <= '0;
          rd_q     <= '0;
          if ((ASIZE+1)'(cnt) == (ASIZE+1)'(R - 1)) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (ok0) mem[bus.wr_addr0] <= post(bus.wr_addr0);
          if (ok1) mem[bus.wr_addr1] <= post(bus.wr_addr1);
          if (bus.rd_en) begin
            for (int p = 0; p < RP; p++) begin
              if (live(bus.rd_addr[p*ASIZE +: ASIZE]))
                rd_q[p*N +: N] <= post(bus.rd_addr[p*ASIZE +: ASIZE]);
              else
                rd_q[p*N +: N] <= '0;
            end
          end
          if (bus.clr) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state  <= S_CLEAR;
          cnt    <= '0;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset sweep, byte merge, dual-write
// conflict, bypass, zero/range handling and mid-sweep restart.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_mp_if #(.N(64), .R(32), .RP(2)) ba ();
  regfile_mp_if #(.N(64), .R(24), .RP(2)) bb ();

  regfile_mp #(.N(64), .R(32), .RP(2), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ba.slave)
  );

  regfile_mp #(.N(64), .R(24), .RP(2), .ZERO_REG(1)) dut24 (
    .clk (clk),
    .rst (rst),
    .bus (bb.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ba.clr = 0; ba.rd_en = 0; ba.wr_en = 0;
    bb.clr = 0; bb.rd_en = 0; bb.wr_en = 0;
  endtask

  task automatic wa(
    input int          a,
    input logic [63:0] d,
    input logic [7:0]  be
  );
    ba.wr_en    = 2'b01;
    ba.wr_addr0 = 5'(a);
    ba.wr_data0 = d;
    ba.wr_be0   = be;
    tick;
    ba.wr_en    = 2'b00;
  endtask

  task automatic ra(input int a0, input int a1);
    ba.rd_en   = 1;
    ba.rd_addr = {5'(a1), 5'(a0)};
    tick;
    ba.rd_en   = 0;
  endtask

  task automatic rb(input int a0, input int a1);
    bb.rd_en   = 1;
    bb.rd_addr = {5'(a1), 5'(a0)};
    tick;
    bb.rd_en   = 0;
  endtask

  int ca;
  int cb;

  initial begin
    idle;
    ba.rd_addr = '0; ba.wr_addr0 = '0; ba.wr_addr1 = '0;
    ba.wr_data0 = '0; ba.wr_data1 = '0;
    ba.wr_be0 = '0; ba.wr_be1 = '0;
    bb.rd_addr = '0; bb.wr_addr0 = '0; bb.wr_addr1 = '0;
    bb.wr_data0 = '0; bb.wr_data1 = '0;
    bb.wr_be0 = '0; bb.wr_be1 = '0;

    // reset
    rst = 1;
    tick;
    tick;
    check("rst_busy", 64'(ba.busy), 64'd1);
    check("rst_rd0", ba.rd_data[63:0], 64'd0);
    check("rst_busy24", 64'(bb.busy), 64'd1);
    rst = 0;
    ba.rd_en = 1;
    ba.rd_addr = {5'd4, 5'd3};
    ca = 0;
    cb = 0;
    for (int i = 0; i < 100 && (ba.busy || bb.busy); i++) begin
      if (ba.busy) ca++;
      if (bb.busy) cb++;
      if (i == 5) check("rd_in_sweep", ba.rd_data[127:64], 64'd0);
      tick;
    end
    ba.rd_en = 0;
    check("sweep_len32", 64'(ca), 64'd32);
    check("sweep_len24", 64'(cb), 64'd24);

    for (int i = 0; i < 16; i++) begin
      ra(i, i + 16);
      check($sformatf("post_rst_r%0d", i),
            ba.rd_data[63:0], 64'd0);
      check($sformatf("post_rst_r%0d", i + 16),
            ba.rd_data[127:64], 64'd0);
    end

    // byte merge
    wa(5, 64'h1111_2222_3333_4444, 8'hFF);
    wa(5, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
    ra(5, 0);
    check("merge_r5", ba.rd_data[63:0], 64'h1111_2222_BBBB_BBBB);
    check("zero_r0", ba.rd_data[127:64], 64'd0);

    // dual write to the same register
    ba.wr_en    = 2'b11;
    ba.wr_addr0 = 5'd7;
    ba.wr_data0 = 64'h0000_0000_0000_00FF;
    ba.wr_be0   = 8'h03;
    ba.wr_addr1 = 5'd7;
    ba.wr_data1 = 64'h0000_0000_0000_AB00;
    ba.wr_be1   = 8'h02;
    tick;
    ba.wr_en = 2'b00;
    ra(7, 5);
    check("dual_r7", ba.rd_data[63:0], 64'h0000_0000_0000_ABFF);
    check("dual_r5", ba.rd_data[127:64], 64'h1111_2222_BBBB_BBBB);

    // bypass, both ports same address
    ba.wr_en    = 2'b01;
    ba.wr_addr0 = 5'd9;
    ba.wr_data0 = 64'h5A;
    ba.wr_be0   = 8'hFF;
    ra(9, 9);
    ba.wr_en = 2'b00;
    check("byp_p0", ba.rd_data[63:0], 64'h5A);
    check("byp_p1", ba.rd_data[127:64], 64'h5A);

    // rd_en low holds
    ba.rd_addr = {5'd5, 5'd7};
    tick;
    check("hold_p0", ba.rd_data[63:0], 64'h5A);

    // bypass with port1 byte merge over existing content
    ba.wr_en    = 2'b10;
    ba.wr_addr1 = 5'd5;
    ba.wr_data1 = 64'hCC00_0000_0000_0000;
    ba.wr_be1   = 8'h80;
    ra(3, 5);
    ba.wr_en = 2'b00;
    check("byp_be_p1", ba.rd_data[127:64], 64'hCC11_2222_BBBB_BBBB);
    check("byp_be_p0", ba.rd_data[63:0], 64'd0);

    // hardwired zero on 32-entry file
    wa(0, 64'hFFFF, 8'hFF);
    ra(0, 31);
    check("w0_ignored", ba.rd_data[63:0], 64'd0);

    // zero and out-of-range on 24-entry file
    bb.wr_en    = 2'b11;
    bb.wr_addr0 = 5'd0;
    bb.wr_data0 = 64'hFF;
    bb.wr_be0   = 8'hFF;
    bb.wr_addr1 = 5'd30;
    bb.wr_data1 = 64'hFF;
    bb.wr_be1   = 8'hFF;
    tick;
    bb.wr_en    = 2'b01;
    bb.wr_addr0 = 5'd23;
    bb.wr_data0 = 64'h77;
    tick;
    bb.wr_en = 2'b00;
    rb(0, 30);
    check("r24_reg0", bb.rd_data[63:0], 64'd0);
    check("r24_reg30", bb.rd_data[127:64], 64'd0);
    rb(23, 1);
    check("r24_reg23", bb.rd_data[63:0], 64'h77);
    check("r24_reg1", bb.rd_data[127:64], 64'd0);

    // clear, then reset at sweep cycle 10 with writes attempted
    ba.clr = 1;
    tick;
    ba.clr = 0;
    check("clr_busy", 64'(ba.busy), 64'd1);
    ba.wr_en    = 2'b11;
    ba.wr_addr0 = 5'd5;
    ba.wr_data0 = '1;
    ba.wr_be0   = 8'hFF;
    ba.wr_addr1 = 5'd12;
    ba.wr_data1 = '1;
    ba.wr_be1   = 8'hFF;
    ba.rd_en    = 1;
    ba.rd_addr  = {5'd12, 5'd5};
    for (int i = 0; i < 10; i++) tick;
    rst = 1;
    tick;
    rst = 0;
    ca = 0;
    for (int i = 0; i < 100 && ba.busy; i++) begin
      ca++;
      ba.clr = (i == 3);
      if (i == 20) check("rd_in_restart", ba.rd_data[63:0], 64'd0);
      tick;
    end
    idle;
    check("restart_len", 64'(ca), 64'd32);
    ra(5, 12);
    check("swp_r5", ba.rd_data[63:0], 64'd0);
    check("swp_r12", ba.rd_data[127:64], 64'd0);
    ra(7, 9);
    check("swp_r7", ba.rd_data[63:0], 64'd0);
    check("swp_r9", ba.rd_data[127:64], 64'd0);
    check("idle_after", 64'(ba.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
